// File: rtl/avion_pkg.sv
// Shared definitions for the avion memory arbiter: default widths, port ids
// and the lock counter helper.
package avion_pkg;

    localparam int AVION_ADDRESS_WIDTH = 6;
    localparam int AVION_DATA_WIDTH    = 10;
    localparam int AVION_LOCK_MAX      = 8;
    localparam int LOCK_CNT_WIDTH      = 8;

    typedef enum logic {
        PORT_CPU = 1'b0,
        PORT_DBG = 1'b1
    } port_e;

    // Advance the consecutive-lock counter, holding it at the release threshold.
    function automatic logic [LOCK_CNT_WIDTH-1:0] lock_cnt_next(
        input logic [LOCK_CNT_WIDTH-1:0] cnt,
        input logic [LOCK_CNT_WIDTH-1:0] max_cnt
    );
        logic [LOCK_CNT_WIDTH-1:0] result;
        if (cnt >= max_cnt) begin
            result = max_cnt;
        end else begin
            result = cnt + 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/avion_rr_pick2.sv
// Two-way round-robin pick with a bounded lock override; purely combinational.
module avion_rr_pick2
    import avion_pkg::*;
#(
    parameter int LOCK_MAX = AVION_LOCK_MAX
) (
    input  logic                      req0,
    input  logic                      req1,
    input  logic                      last_winner,
    input  logic                      owner_locked,
    input  logic [LOCK_CNT_WIDTH-1:0] lock_cnt,
    output logic                      gnt0,
    output logic                      gnt1
);

    localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_MAX_C = LOCK_CNT_WIDTH'(LOCK_MAX);

    logic lock_hold;
    logic contended_winner;

    // The owner is always last_winner, so under contention the owner is requesting.
    assign lock_hold = owner_locked && (lock_cnt < LOCK_MAX_C);

    always_comb begin
        gnt0             = 1'b0;
        gnt1             = 1'b0;
        contended_winner = lock_hold ? last_winner : ~last_winner;
        if (req0 && req1) begin
            gnt0 = (contended_winner == PORT_CPU);
            gnt1 = (contended_winner == PORT_DBG);
        end else if (req0) begin
            gnt0 = 1'b1;
        end else if (req1) begin
            gnt1 = 1'b1;
        end
    end

endmodule

// File: rtl/avion_mem_arbiter.sv
// Shares the single-port block RAM between the CPU and the debug/loader master,
// routing each registered read result back to the port that issued it.
module avion_mem_arbiter
    import avion_pkg::*;
#(
    parameter int ADDRESS_WIDTH = AVION_ADDRESS_WIDTH,
    parameter int DATA_WIDTH    = AVION_DATA_WIDTH,
    parameter int LOCK_MAX      = AVION_LOCK_MAX
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     req0,
    input  logic                     req1,
    input  logic                     we0,
    input  logic                     we1,
    input  logic                     lock0,
    input  logic                     lock1,
    input  logic [ADDRESS_WIDTH-1:0] addr0,
    input  logic [ADDRESS_WIDTH-1:0] addr1,
    input  logic [DATA_WIDTH-1:0]    wdata0,
    input  logic [DATA_WIDTH-1:0]    wdata1,
    output logic                     gnt0,
    output logic                     gnt1,
    output logic                     rvalid0,
    output logic                     rvalid1,
    output logic [DATA_WIDTH-1:0]    rdata0,
    output logic [DATA_WIDTH-1:0]    rdata1,
    output logic                     ram_we,
    output logic [ADDRESS_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0]    ram_wdata,
    input  logic [DATA_WIDTH-1:0]    ram_rdata
);

    localparam logic [LOCK_CNT_WIDTH-1:0] LOCK_MAX_C = LOCK_CNT_WIDTH'(LOCK_MAX);

    logic                      last_winner_q, last_winner_d;
    logic                      owner_locked_q, owner_locked_d;
    logic [LOCK_CNT_WIDTH-1:0] lock_cnt_q, lock_cnt_d;
    logic                      rd_pending_q, rd_pending_d;
    logic                      rd_port_q, rd_port_d;

    logic  pick_gnt0;
    logic  pick_gnt1;
    logic  grant_any;
    port_e grant_port;
    logic  grant_we;
    logic  grant_lock;

    avion_rr_pick2 #(
        .LOCK_MAX(LOCK_MAX)
    ) u_pick (
        .req0        (req0),
        .req1        (req1),
        .last_winner (last_winner_q),
        .owner_locked(owner_locked_q),
        .lock_cnt    (lock_cnt_q),
        .gnt0        (pick_gnt0),
        .gnt1        (pick_gnt1)
    );

    // Grants are suppressed while reset is held so nothing reaches the RAM.
    always_comb begin
        gnt0       = pick_gnt0 & ~rst;
        gnt1       = pick_gnt1 & ~rst;
        grant_any  = gnt0 | gnt1;
        grant_port = gnt1 ? PORT_DBG : PORT_CPU;
        grant_we   = gnt1 ? we1 : we0;
        grant_lock = gnt1 ? lock1 : lock0;
    end

    always_comb begin
        last_winner_d  = last_winner_q;
        owner_locked_d = 1'b0;
        lock_cnt_d     = lock_cnt_q;
        rd_pending_d   = 1'b0;
        rd_port_d      = rd_port_q;
        if (grant_any) begin
            last_winner_d = grant_port;
            if (grant_lock) begin
                owner_locked_d = 1'b1;
                if (owner_locked_q && (last_winner_q == grant_port)) begin
                    lock_cnt_d = lock_cnt_next(lock_cnt_q, LOCK_MAX_C);
                end else begin
                    lock_cnt_d = LOCK_CNT_WIDTH'(1);
                end
            end else begin
                lock_cnt_d = '0;
            end
            if (!grant_we) begin
                rd_pending_d = 1'b1;
                rd_port_d    = grant_port;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_winner_q  <= PORT_DBG;
            owner_locked_q <= 1'b0;
            lock_cnt_q     <= '0;
            rd_pending_q   <= 1'b0;
            rd_port_q      <= PORT_CPU;
        end else begin
            last_winner_q  <= last_winner_d;
            owner_locked_q <= owner_locked_d;
            lock_cnt_q     <= lock_cnt_d;
            rd_pending_q   <= rd_pending_d;
            rd_port_q      <= rd_port_d;
        end
    end

    always_comb begin
        ram_we    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (gnt0) begin
            ram_we    = we0;
            ram_addr  = addr0;
            ram_wdata = wdata0;
        end else if (gnt1) begin
            ram_we    = we1;
            ram_addr  = addr1;
            ram_wdata = wdata1;
        end
    end

    // The RAM result from the previous cycle belongs only to the port that read.
    always_comb begin
        rvalid0 = rd_pending_q && (rd_port_q == PORT_CPU) && !rst;
        rvalid1 = rd_pending_q && (rd_port_q == PORT_DBG) && !rst;
        rdata0  = rvalid0 ? ram_rdata : '0;
        rdata1  = rvalid1 ? ram_rdata : '0;
    end

endmodule

// File: tb/tb_avion_mem_arbiter.sv
// Self-checking bench for avion_mem_arbiter: vector table, lock/reset sequences
// and a read-return scoreboard against a bench-side RAM model.
module tb_avion_mem_arbiter;

    logic       clk;
    logic       rst;
    logic       req0, req1, we0, we1, lock0, lock1;
    logic [5:0] addr0, addr1;
    logic [9:0] wdata0, wdata1;
    logic       gnt0, gnt1, rvalid0, rvalid1;
    logic [9:0] rdata0, rdata1;
    logic       ram_we;
    logic [5:0] ram_addr;
    logic [9:0] ram_wdata;
    logic [9:0] ram_rdata;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst, req0, req1, we0, we1, lock0, lock1;
        logic [5:0] addr0, addr1;
        logic [9:0] wdata0, wdata1;
        logic       exp_gnt0, exp_gnt1;
    } vec_t;

    typedef struct {
        logic       port;
        logic [9:0] data;
    } exp_t;

    logic [9:0] ram_mem [64];
    logic [9:0] shadow  [64];
    exp_t       exp_q[$];

    avion_mem_arbiter dut (
        .clk      (clk),
        .rst      (rst),
        .req0     (req0),
        .req1     (req1),
        .we0      (we0),
        .we1      (we1),
        .lock0    (lock0),
        .lock1    (lock1),
        .addr0    (addr0),
        .addr1    (addr1),
        .wdata0   (wdata0),
        .wdata1   (wdata1),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .rvalid0  (rvalid0),
        .rvalid1  (rvalid1),
        .rdata0   (rdata0),
        .rdata1   (rdata1),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        for (int i = 0; i < 64; i++) begin
            ram_mem[i] = 10'(i);
            shadow[i]  = 10'(i);
        end
        ram_mem[50] = 10'd5;
        shadow[50]  = 10'd5;
        ram_mem[51] = 10'd10;
        shadow[51]  = 10'd10;
    end

    // Single-port RAM with registered, write-first read output.
    always @(posedge clk) begin
        ram_rdata <= ram_we ? ram_wdata : ram_mem[ram_addr];
        if (ram_we) ram_mem[ram_addr] = ram_wdata;
    end

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
        end
    endtask

    // Scoreboard: each cycle, retire last cycle's read and log this cycle's access.
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            check("rst gnt0", gnt0, 0);
            check("rst gnt1", gnt1, 0);
            check("rst rvalid0", rvalid0, 0);
            check("rst rvalid1", rvalid1, 0);
            check("rst ram_we", ram_we, 0);
            check("rst ram_addr", ram_addr, 0);
            check("rst ram_wdata", ram_wdata, 0);
            exp_q.delete();
        end else begin
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("sb rvalid0", rvalid0, (e.port == 1'b0));
                check("sb rvalid1", rvalid1, (e.port == 1'b1));
                check("sb rdata0", rdata0, (e.port == 1'b0) ? e.data : 10'd0);
                check("sb rdata1", rdata1, (e.port == 1'b1) ? e.data : 10'd0);
            end else begin
                check("sb idle rvalid0", rvalid0, 0);
                check("sb idle rvalid1", rvalid1, 0);
            end
            if (gnt0 && gnt1) begin
                check("sb single grant", 2, 1);
            end else if (gnt0) begin
                check("sb gnt0 has req", req0, 1);
                check("sb ram_addr p0", ram_addr, addr0);
                check("sb ram_we p0", ram_we, we0);
                if (we0) begin
                    check("sb ram_wdata p0", ram_wdata, wdata0);
                    shadow[addr0] = wdata0;
                end else begin
                    exp_q.push_back('{port: 1'b0, data: shadow[addr0]});
                end
            end else if (gnt1) begin
                check("sb gnt1 has req", req1, 1);
                check("sb ram_addr p1", ram_addr, addr1);
                check("sb ram_we p1", ram_we, we1);
                if (we1) begin
                    check("sb ram_wdata p1", ram_wdata, wdata1);
                    shadow[addr1] = wdata1;
                end else begin
                    exp_q.push_back('{port: 1'b1, data: shadow[addr1]});
                end
            end else begin
                check("sb idle ram_we", ram_we, 0);
                check("sb idle ram_addr", ram_addr, 0);
                check("sb idle ram_wdata", ram_wdata, 0);
            end
        end
    end

    function automatic vec_t mk(input logic rs, r0, r1, w0, w1, l0, l1,
                                input logic [5:0] a0, a1, input logic [9:0] d0, d1,
                                input logic g0, g1);
        vec_t v;
        v.rst = rs; v.req0 = r0; v.req1 = r1; v.we0 = w0; v.we1 = w1;
        v.lock0 = l0; v.lock1 = l1; v.addr0 = a0; v.addr1 = a1;
        v.wdata0 = d0; v.wdata1 = d1; v.exp_gnt0 = g0; v.exp_gnt1 = g1;
        return v;
    endfunction

    task automatic apply_stimulus(input vec_t v);
        rst = v.rst; req0 = v.req0; req1 = v.req1; we0 = v.we0; we1 = v.we1;
        lock0 = v.lock0; lock1 = v.lock1; addr0 = v.addr0; addr1 = v.addr1;
        wdata0 = v.wdata0; wdata1 = v.wdata1;
    endtask

    task automatic check_output(input string name, input logic g0, input logic g1);
        check({name, " gnt0"}, gnt0, g0);
        check({name, " gnt1"}, gnt1, g1);
    endtask

    task automatic idle_inputs();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = 0; addr1 = 0; wdata0 = 0; wdata1 = 0;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    vec_t vecs[26];

    initial begin
        int  k, n0, n1;
        logic s0, s1;
        rst = 1'b1;
        idle_inputs();

        for (int i = 0; i < 3; i++) vecs[i] = mk(1,1,1,0,0,0,0,50,51,0,0,0,0);
        for (int i = 3; i < 9; i++) vecs[i] = mk(0,1,1,0,0,0,0,50,51,0,0,(i%2)==1,(i%2)==0);
        vecs[9]  = mk(0,0,0,0,0,0,0, 0, 0,0, 0,0,0);
        vecs[10] = mk(0,1,0,0,0,0,0,50, 0,0, 0,1,0);
        vecs[11] = mk(0,0,0,0,0,0,0, 0, 0,0, 0,0,0);
        vecs[12] = mk(0,0,1,0,1,0,0, 0,52,0,15,0,1);
        vecs[13] = mk(0,1,0,0,0,0,0,52, 0,0, 0,1,0);
        vecs[14] = mk(0,0,0,0,0,0,0, 0, 0,0, 0,0,0);
        vecs[15] = mk(0,0,1,0,0,0,0, 0,51,0, 0,0,1);
        vecs[16] = mk(0,0,1,0,0,0,0, 0,51,0, 0,0,1);
        vecs[17] = mk(0,1,1,1,1,0,0,53,54,7, 9,1,0);
        vecs[18] = mk(0,1,1,0,0,0,0,53,54,0, 0,0,1);
        vecs[19] = mk(0,1,1,0,0,0,0,53,54,0, 0,1,0);
        vecs[20] = mk(0,0,0,0,0,0,0, 0, 0,0, 0,0,0);
        vecs[21] = mk(0,1,0,0,0,1,0,50, 0,0, 0,1,0);
        vecs[22] = mk(0,1,1,0,0,1,0,50,51,0, 0,1,0);
        vecs[23] = mk(0,1,1,0,0,0,0,50,51,0, 0,1,0);
        vecs[24] = mk(0,1,1,0,0,0,0,50,51,0, 0,0,1);
        vecs[25] = mk(0,0,0,0,0,0,0, 0, 0,0, 0,0,0);

        next_cycle();
        for (int i = 0; i < 26; i++) begin
            apply_stimulus(vecs[i]);
            @(negedge clk);
            check_output($sformatf("vec%0d", i), vecs[i].exp_gnt0, vecs[i].exp_gnt1);
            next_cycle();
        end

        // Port 1 burst of locked writes to 0..11 while port 0 waits for one read.
        $display("[TB] lock burst with starvation bound");
        k = 0; n0 = 0; n1 = 0;
        idle_inputs();
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 0; wdata1 = 10'd100;
        for (int c = 0; c < 13; c++) begin
            @(negedge clk);
            s0 = gnt0;
            s1 = gnt1;
            check_output($sformatf("lock c%0d", c), (c == 8), (c != 8));
            next_cycle();
            if (s0) begin
                n0++;
                req0 = 0;
            end else if (c == 0) begin
                req0 = 1; we0 = 0; lock0 = 0; addr0 = 50;
            end
            if (s1) begin
                n1++;
                k++;
                if (k >= 12) begin
                    req1 = 0; lock1 = 0; we1 = 0;
                end else begin
                    addr1 = 6'(k);
                    wdata1 = 10'(100 + k);
                end
            end
        end
        check("lock p1 grants", n1, 12);
        check("lock p0 grants", n0, 1);
        idle_inputs();

        // Read back two of the burst words.
        req0 = 1; addr0 = 3;
        @(negedge clk);
        check_output("rb3", 1, 0);
        next_cycle();
        addr0 = 11;
        @(negedge clk);
        check_output("rb11", 1, 0);
        check("rb3 rvalid0", rvalid0, 1);
        check("rb3 rdata0", rdata0, 103);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("rb11 rvalid0", rvalid0, 1);
        check("rb11 rdata0", rdata0, 111);
        next_cycle();

        // Owner alone past the bound keeps the grant; the other port then wins.
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 20; wdata1 = 10'd77;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check_output($sformatf("sat c%0d", c), 0, 1);
            next_cycle();
        end
        req0 = 1; addr0 = 50;
        @(negedge clk);
        check_output("sat release", 1, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        check("sat read rdata0", rdata0, 5);
        next_cycle();

        // Reset lands on the cycle the read result would return.
        req0 = 1; addr0 = 50;
        @(negedge clk);
        check_output("rstrd", 1, 0);
        next_cycle();
        idle_inputs();
        rst = 1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check("rstrd rvalid0 in rst", rvalid0, 0);
            next_cycle();
        end
        rst = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("rstrd rvalid0 after", rvalid0, 0);
            check("rstrd rvalid1 after", rvalid1, 0);
            next_cycle();
        end
        req0 = 1; req1 = 1; addr0 = 50; addr1 = 51;
        @(negedge clk);
        check_output("post rst tie", 1, 0);
        next_cycle();
        idle_inputs();
        @(negedge clk);
        next_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/avion_mem_arbiter.md
Name: avion_mem_arbiter

Overview:
Two-requester arbiter that shares the single-port 64x10 block RAM between the avion CPU (port 0) and a debug/loader master (port 1, driven from board switches/buttons). It issues at most one RAM access per cycle, grants round-robin with an optional bounded lock for bursts, and tracks the RAM's 1-cycle registered read latency so each requester receives only its own read data.

Parameters:
ADDRESS_WIDTH, 6, RAM address width.
DATA_WIDTH, 10, RAM word width.
LOCK_MAX, 8, max consecutive locked grants to one port before forced release (1..255).

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
req0, req1  in  1 each  access request, held until granted
we0, we1  in  1 each  1 = write, 0 = read; valid with req
lock0, lock1  in  1 each  request to keep ownership on following cycles
addr0, addr1  in  ADDRESS_WIDTH each  word address
wdata0, wdata1  in  DATA_WIDTH each  write data
gnt0, gnt1  out  1 each  access issued to RAM this cycle (combinational)
rvalid0, rvalid1  out  1 each  read data valid (registered)
rdata0, rdata1  out  DATA_WIDTH each  read data, meaningful only with rvalid
ram_we  out  1  RAM write enable
ram_addr  out  ADDRESS_WIDTH  RAM address
ram_wdata  out  DATA_WIDTH  RAM write data
ram_rdata  in  DATA_WIDTH  RAM registered read output

Behaviour:
- Clock/reset: single clock clk; rst synchronous, active-high.
- State: last_winner (1 bit), owner_locked (1 bit), lock_cnt (8 bit), rd_pending (1 bit), rd_port (1 bit).
- Reset values: last_winner=1 (port 0 wins first tie), owner_locked=0, lock_cnt=0, rd_pending=0, rd_port=0. During rst: gnt0=gnt1=0, ram_we=0, ram_addr=0, ram_wdata=0, rvalid0=rvalid1=0, rdata=0.
- Arbitration (combinational, same cycle):
  - Only one requester -> it is granted.
  - Both requesting, no active lock -> grant the port != last_winner.
  - Active lock (owner_locked=1, owner still requesting, lock_cnt < LOCK_MAX) -> owner granted regardless of the other port.
  - lock_cnt == LOCK_MAX with other port requesting -> other port granted, lock cleared. Owner alone -> grant continues, lock_cnt saturates.
  - Owner drops req -> lock released the same cycle; normal rules apply.
- Lock update on clock edge: a grant with lockN=1 sets owner_locked=1, last_winner=N, and lock_cnt = (previous owner was N and locked) ? lock_cnt+1 : 1. A grant with lockN=0 clears owner_locked and lock_cnt. No grant -> owner_locked cleared.
- RAM drive: granted port's addr/wdata to ram_addr/ram_wdata; ram_we = granted port's we. No grant -> ram_we=0, ram_addr=0, ram_wdata=0.
- Read return: granted read in cycle N sets rd_pending=1, rd_port=N's port at edge; in cycle N+1 rvalid[rd_port]=1, rdata[rd_port]=ram_rdata. The other port's rdata=0. Back-to-back reads from alternating ports are supported (one per cycle).
- Writes: no rvalid. A write to address A in cycle N followed by a read of A in N+1 returns the new data (RAM write-first timing); the bench checks this.
- rst asserted with a read in flight -> rd_pending cleared, no rvalid after reset.
- Address: no wrap or bounds logic; full ADDRESS_WIDTH passed through.

Decomposition:
- Shared package avion_pkg: ADDRESS_WIDTH/DATA_WIDTH defaults, PORT_CPU=0, PORT_DBG=1, LOCK_MAX default.
- One natural sub-module: avion_rr_pick2 (2-way round-robin pick with lock override, purely combinational). The rest is a flat sequential block.

Test Plan:
- Reset: hold rst 3 cycles with req0=req1=1 -> gnt0=gnt1=0, ram_we=0, rvalid=0. First cycle after release -> gnt0=1.
- Single read: port0 read addr 50 (RAM holds 5) -> gnt0 in cycle N; rvalid0=1, rdata0=5 in N+1; rvalid1=0.
- Simultaneous contention: both ports read continuously (addr 50 / 51, values 5 / 10) for 6 cycles -> grants alternate 0,1,0,1,0,1; each rvalid carries 5 or 10 to the correct port.
- Lock with starvation bound (LOCK_MAX=8): port1 writes addr 0..11 with lock1=1 while port0 requests -> port1 gets 8 grants, port0 gets 1, then port1 resumes.
- Write-then-read: port1 writes 15 to addr 52 in cycle N; port0 reads 52 in N+1 -> rdata0=15 in N+2.
- Reset mid-read: rst asserted the cycle after gnt0 for a read -> no rvalid0 in any following cycle.
